// File: rtl/bus_rr.sv
// bus_rr: shared-bus interconnect with a round-robin arbiter, an optional hold limit,
// a windowed address decoder and a registered read-return select.
module bus_rr #(
  parameter int unsigned NUM_M    = 2,
  parameter int unsigned NUM_S    = 2,
  parameter int unsigned AW       = 8,
  parameter int unsigned DW       = 32,
  parameter int unsigned WIN_BITS = 5,
  parameter int unsigned MAX_HOLD = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_M-1:0]    m_req,
  input  logic [NUM_M-1:0]    m_wr,
  input  logic [NUM_M*AW-1:0] m_address,
  input  logic [NUM_M*DW-1:0] m_dout,
  output logic [NUM_M-1:0]    m_grant,
  output logic [DW-1:0]       m_din,
  input  logic [NUM_S*DW-1:0] s_dout,
  output logic [NUM_S-1:0]    s_sel,
  output logic [AW-1:0]       s_address,
  output logic                s_wr,
  output logic [DW-1:0]       s_din,
  output logic                s_err
);

  localparam int unsigned MW  = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int unsigned HW  = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int unsigned AW1 = AW + 1;
  // Terminal hold count; the counter saturates here so a late competitor still hits the limit.
  localparam logic [HW-1:0] HoldLast = (MAX_HOLD == 0) ? '0 : HW'(MAX_HOLD - 1);

  logic [NUM_M-1:0] grant_q, grant_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [NUM_S-1:0] rsel_q;
  logic             err_q, err_d;
  logic [MW-1:0]    owner, next_owner;
  logic [AW-1:0]    slv_idx;
  logic             active, mapped, others_req, hold_hit, found;
  int unsigned      idx;

  assign m_grant = grant_q;
  assign s_err   = err_q;

  // Encode the one-hot grant into the owner index.
  always_comb begin
    owner = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (grant_q[i]) owner = MW'(i);
    end
  end

  assign s_address = m_address[owner*AW +: AW];
  assign s_wr      = m_wr[owner];
  assign s_din     = m_dout[owner*DW +: DW];

  // Address decode: one window per slave; anything above the last slave is unmapped.
  always_comb begin
    active  = m_req[owner];
    slv_idx = s_address >> WIN_BITS;
    mapped  = ({1'b0, slv_idx} < AW1'(NUM_S));
    s_sel   = '0;
    for (int k = 0; k < NUM_S; k++) begin
      s_sel[k] = active && ({1'b0, slv_idx} == AW1'(k));
    end
    err_d = active && !mapped;
  end

  // Read return uses the select registered from the previous address phase.
  always_comb begin
    m_din = '0;
    for (int k = 0; k < NUM_S; k++) begin
      if (rsel_q[k]) m_din = m_din | s_dout[k*DW +: DW];
    end
  end

  // Round-robin arbitration with hold limit and hold-counter next state.
  always_comb begin
    others_req = |(m_req & ~grant_q);
    hold_hit   = (MAX_HOLD != 0) && (hold_q == HoldLast) && others_req;
    next_owner = owner;
    found      = 1'b0;
    idx        = 0;
    if (!(m_req[owner] && !hold_hit) && others_req) begin
      for (int i = 1; i < NUM_M; i++) begin
        idx = (int'(owner) + i) % NUM_M;
        if (!found && m_req[idx]) begin
          next_owner = MW'(idx);
          found      = 1'b1;
        end
      end
    end
    grant_d             = '0;
    grant_d[next_owner] = 1'b1;
    if (next_owner == owner && m_req[owner]) begin
      hold_d = (MAX_HOLD == 0 || hold_q == HoldLast) ? hold_q : hold_q + 1'b1;
    end else begin
      hold_d = '0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q <= NUM_M'(1);
      hold_q  <= '0;
      rsel_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      grant_q <= grant_d;
      hold_q  <= hold_d;
      rsel_q  <= s_sel;
      err_q   <= err_d;
    end
  end

endmodule
